// File: rtl/skew_stream_buf.sv
// Skew buffer: delays each lane of a streamed operand tile, then zero-fills until drained.
// Optional SKEWBUF_REVERSE_EN makes the last lane lead instead of lane 0.
module skew_stream_buf #(
    parameter int BITS_AB  = 8,
    parameter int DIM      = 8,
    parameter int MAXK     = 16,
    parameter int BASE_LAT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [$clog2(MAXK+1)-1:0]   k_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DIM*BITS_AB-1:0]      Bin,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [DIM*BITS_AB-1:0]      Bout,
    output logic                        busy,
    output logic                        done
);

    localparam int NDRAIN = BASE_LAT + DIM - 2;
    localparam int CW     = $clog2(MAXK + BASE_LAT + DIM + 1);
    localparam bit NODRAIN = (NDRAIN == 0);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   k_q, k_d;
    logic            done_q, done_d;
    logic            out_valid_q;
    logic            step;
    logic            clr;

    assign clr  = (state_q == IDLE) && start && (k_len != '0);
    assign step = ((state_q == LOAD) && in_valid && out_ready) ||
                  ((state_q == DRAIN) && out_ready);

    assign in_ready  = (state_q == LOAD) && out_ready;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    if (int'(k_len) > MAXK) k_d = CW'(MAXK);
                    else                    k_d = CW'(k_len);
                end
            end
            LOAD: begin
                if (step) begin
                    if (cnt_q == k_q - 1'b1) begin
                        cnt_d = '0;
                        // Degenerate geometry: nothing left in flight after the last vector
                        if (NODRAIN) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (step) begin
                    if (cnt_q == CW'(NDRAIN - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            done_q      <= done_d;
            out_valid_q <= step;
        end
    end

    for (genvar c = 0; c < DIM; c++) begin : g_lane
`ifdef SKEWBUF_REVERSE_EN
        localparam int D = BASE_LAT + DIM - 1 - c;
`else
        localparam int D = BASE_LAT + c;
`endif
        logic [BITS_AB-1:0] sr_q [D];
        logic [BITS_AB-1:0] din;

        // Once loading ends the lanes are flushed with zeros
        assign din = (state_q == LOAD) ? Bin[c*BITS_AB +: BITS_AB] : '0;

        always_ff @(posedge clk) begin
            if (rst || clr) begin
                for (int j = 0; j < D; j++) sr_q[j] <= '0;
            end else if (step) begin
                sr_q[0] <= din;
                for (int j = 1; j < D; j++) sr_q[j] <= sr_q[j-1];
            end
        end

        assign Bout[c*BITS_AB +: BITS_AB] = sr_q[D-1];
    end

endmodule

// File: tb/tb_skew_stream_buf.sv
// Randomised and directed bench for skew_stream_buf against a tile-level model.
// The model derives each output from the list of accepted vectors and the step index.
module tb_skew_stream_buf;

    localparam int BITS_AB  = 8;
    localparam int DIM      = 4;
    localparam int MAXK     = 16;
    localparam int BASE_LAT = 4;
    localparam int KW       = $clog2(MAXK + 1);
    localparam int XTRA     = BASE_LAT + DIM - 2;
    localparam int W        = DIM * BITS_AB;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  Bin;
    logic          out_ready;
    logic          out_valid;
    logic [W-1:0]  Bout;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    skew_stream_buf #(
        .BITS_AB (BITS_AB),
        .DIM     (DIM),
        .MAXK    (MAXK),
        .BASE_LAT(BASE_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Bin      (Bin),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .Bout     (Bout),
        .busy     (busy),
        .done     (done)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model state
    bit           m_act = 1'b0;
    int           m_k   = 0;
    int           m_n   = 0;
    logic [W-1:0] m_vec [$];
    logic [W-1:0] m_bout = '0;
    bit           m_ov   = 1'b0;
    bit           m_done = 1'b0;

    int           cyc_n   = 0;
    int           pulses  = 0;
    int           dones   = 0;
    int           done_at = 0;
    logic [W-1:0] cap [64];

    function automatic int dly(input int c);
`ifdef SKEWBUF_REVERSE_EN
        return BASE_LAT + DIM - 1 - c;
`else
        return BASE_LAT + c;
`endif
    endfunction

    function automatic logic [W-1:0] bout_at(input int s);
        logic [W-1:0] r;
        logic [W-1:0] v;
        int idx;
        r = '0;
        for (int c = 0; c < DIM; c++) begin
            idx = s - dly(c) + 1;
            if (idx >= 0 && idx < m_k) begin
                v = m_vec[idx];
                r[c*BITS_AB +: BITS_AB] = v[c*BITS_AB +: BITS_AB];
            end
        end
        return r;
    endfunction

    task automatic cyc();
        bit           stp;
        bit           ir;
        bit           s_rst, s_start, s_iv;
        logic [KW-1:0] s_kl;
        logic [W-1:0] s_bin;
        @(negedge clk);
        ir  = m_act && (m_n < m_k) && out_ready;
        stp = m_act && out_ready && ((m_n >= m_k) || in_valid);
        chk("in_ready", 64'(in_ready), 64'(ir));
        chk("busy", 64'(busy), 64'(m_act));
        s_rst = rst; s_start = start; s_iv = in_valid;
        s_kl = k_len; s_bin = Bin;
        @(posedge clk);
        #1;
        cyc_n++;
        if (s_rst) begin
            m_act = 1'b0; m_bout = '0; m_ov = 1'b0; m_done = 1'b0;
        end else if (!m_act) begin
            m_ov = 1'b0; m_done = 1'b0;
            if (s_start && s_kl != '0) begin
                m_act  = 1'b1;
                m_k    = (int'(s_kl) > MAXK) ? MAXK : int'(s_kl);
                m_n    = 0;
                m_vec.delete();
                m_bout = '0;
            end
        end else begin
            m_done = 1'b0;
            m_ov   = stp;
            if (stp) begin
                if (m_n < m_k && s_iv) m_vec.push_back(s_bin);
                m_bout = bout_at(m_n);
                if (m_n < 64) cap[m_n] = Bout;
                m_n++;
                if (m_n == m_k + XTRA) begin
                    m_act = 1'b0; m_done = 1'b1;
                end
            end
        end
        chk("Bout", 64'(Bout), 64'(m_bout));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("done", 64'(done), 64'(m_done));
        if (out_valid) pulses++;
        if (done) begin dones++; done_at = cyc_n; end
    endtask

    task automatic quiet();
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rst = 1'b0;
        k_len = '0; Bin = W'($urandom);
    endtask

    task automatic finish_tile(input string tag, input int rdy_pct);
        for (int i = 0; i < 400 && m_act; i++) begin
            out_ready = ($urandom_range(99) < rdy_pct);
            in_valid  = $urandom_range(1);
            Bin       = W'($urandom);
            cyc();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        if (m_act) chk({tag, " timeout"}, 64'(busy), 64'(0));
    endtask

    task automatic load_t1();
        start = 1'b1; k_len = KW'(2); cyc();
        start = 1'b0; in_valid = 1'b1;
        Bin = {8'd4, 8'd3, 8'd2, 8'd1}; cyc();
        Bin = {8'd8, 8'd7, 8'd6, 8'd5}; cyc();
        in_valid = 1'b0;
    endtask

    task automatic t1_consts(input string tag);
`ifdef SKEWBUF_REVERSE_EN
        chk({tag, " lane3@3"}, 64'(cap[3][31:24]), 64'd4);
        chk({tag, " lane0@6"}, 64'(cap[6][7:0]), 64'd1);
`else
        chk({tag, " lane0@3"}, 64'(cap[3][7:0]), 64'd1);
        chk({tag, " lane0@4"}, 64'(cap[4][7:0]), 64'd5);
        chk({tag, " lane3@6"}, 64'(cap[6][31:24]), 64'd4);
        chk({tag, " lane3@7"}, 64'(cap[7][31:24]), 64'd8);
`endif
        chk({tag, " pulses"}, 64'(pulses), 64'd8);
        chk({tag, " dones"}, 64'(dones), 64'd1);
    endtask

    int s0;

    initial begin
        quiet();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_act = 1'b0; m_bout = '0;
        cyc();

        // directed tile, continuous flow
        rst = 1'b0; pulses = 0; dones = 0;
        s0 = cyc_n + 1;
        load_t1();
        for (int i = 0; i < 40 && m_act; i++) cyc();
        cyc();
        t1_consts("t1");
        chk("t1 done time", 64'(done_at - s0), 64'd8);

        // same tile with a 3-cycle stall in drain
        pulses = 0; dones = 0;
        s0 = cyc_n + 1;
        load_t1();
        cyc();
        out_ready = 1'b0;
        repeat (3) cyc();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && m_act; i++) cyc();
        cyc();
        t1_consts("t2");
        chk("t2 done time", 64'(done_at - s0), 64'd11);

        // K=3 with input gaps
        start = 1'b1; k_len = KW'(3); cyc();
        start = 1'b0;
        for (int i = 0; i < 20 && m_n < 3; i++) begin
            in_valid = (i % 2 == 1);
            Bin = W'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 40 && m_act; i++) cyc();
        chk("t3 len", 64'(m_vec.size()), 64'd3);

        // k_len=0 ignored, then oversize k_len clamps to MAXK
        dones = 0;
        start = 1'b1; k_len = '0; cyc();
        start = 1'b0; repeat (3) cyc();
        chk("t4 zero done", 64'(dones), 64'd0);
        pulses = 0;
        start = 1'b1; k_len = KW'(20); cyc();
        start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 100 && m_act; i++) begin
            Bin = W'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk("t4 steps", 64'(pulses), 64'd22);

        // reset mid-drain, then a fresh tile
        dones = 0;
        load_t1();
        repeat (2) cyc();
        rst = 1'b1; cyc();
        rst = 1'b0; repeat (3) cyc();
        chk("t5 no done", 64'(dones), 64'd0);
        pulses = 0;
        load_t1();
        for (int i = 0; i < 40 && m_act; i++) cyc();
        cyc();
        chk("t5 pulses", 64'(pulses), 64'd8);

        // random tiles with back-pressure, gaps and stray starts
        for (int t = 0; t < 30; t++) begin
            start = 1'b1;
            k_len = KW'($urandom_range(20));
            cyc();
            start = 1'b0;
            for (int i = 0; i < 400 && m_act; i++) begin
                out_ready = ($urandom_range(99) < 75);
                in_valid  = $urandom_range(1);
                start     = ($urandom_range(9) == 0);
                k_len     = KW'($urandom_range(20));
                rst       = ($urandom_range(299) == 0);
                Bin       = W'($urandom);
                cyc();
            end
            quiet();
            cyc();
        end
        finish_tile("tail", 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
